ex_muldiv: RTL and testbench
============================

// Module: ex_muldiv
// PURPOSE
//  Iterative RV32M multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register.
//  Accepts one MUL*/DIV*/REM* op and stalls the front end through the hold controller until done.
//  Returns a 32-bit result with its destination register address for the EX/MEM write-back path.
// PARAMETERS
//  XLEN     32  operand/result width; only 32 is supported.
//  CNT_W    6   iteration counter width; must hold values 0..XLEN.
// PORTS
//  clk           in   1     pipeline clock (single clock domain)
//  rst           in   1     asynchronous, active-high reset
//  start_i       in   1     op valid from ID/EX; sampled only in IDLE
//  op_i          in   3     funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  rs1_data_i    in   32    dividend / multiplicand
//  rs2_data_i    in   32    divisor / multiplier
//  w_reg_addr_i  in   5     destination register of the op
//  flush_i       in   1     pipeline flush: abort the current op
//  busy_o        out  1     state != IDLE
//  hold_req_o    out  1     stall request to the hold controller (combinational)
//  done_o        out  1     one-cycle pulse; result_o and w_reg_addr_o are valid
//  result_o      out  32    result; holds its value until the next done_o
//  w_reg_addr_o  out  5     destination register latched at start
// BEHAVIOUR
//  Reset: async on rst=1. State -> IDLE; counter, result_o, w_reg_addr_o, done_o, busy_o all 0.
//  FSM states: IDLE -> CALC -> DONE -> IDLE.
//  IDLE, start_i=1, flush_i=0 (cycle T):
//   - latch |rs1|, |rs2|, the result-sign flag, the op and w_reg_addr_i; counter=0.
//   - next state is CALC, or DONE when a shortcut applies.
//  Operand signedness:
//   - MUL/MULH and DIV/REM: both operands signed.
//   - MULHSU: rs1 signed, rs2 unsigned.
//   - MULHU/DIVU/REMU: both operands unsigned.
//  Multiply (CALC): shift-add on a 64-bit accumulator, one multiplier bit per cycle, 32 cycles.
//   - negate the 64-bit product when the result-sign flag is set.
//   - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
//  Divide (CALC): radix-2 restoring, one quotient bit per cycle, 32 cycles.
//   - quotient sign = sign(rs1) XOR sign(rs2); remainder takes the sign of rs1.
//  CALC -> DONE when counter reaches 31; counter increments once per CALC cycle.
//  Latency: start at T, CALC during T+1..T+32, done_o=1 at T+33.
//  DONE: done_o=1 for exactly one cycle, result_o registered; next state is IDLE.
//  A new start_i may be accepted in the cycle after DONE (back-to-back issue).
//  hold_req_o = (IDLE & start_i & ~flush_i) | CALC. It is deasserted in DONE so ID/EX advances then.
//  Shortcuts (skip CALC, done_o at T+1):
//   - divide by zero: DIV/DIVU -> 0xFFFF_FFFF; REM/REMU -> rs1.
//   - overflow DIV/REM with rs1=0x8000_0000 and rs2=0xFFFF_FFFF: DIV -> 0x8000_0000; REM -> 0.
//  flush_i=1 in any state: next state IDLE, no done_o, result_o unchanged. Flush wins over start_i.
//  start_i while busy: ignored. Upstream is stalled by hold_req_o, so it holds the op.
//  Reset during CALC: op abandoned immediately; no done_o after reset release.
//  rs1=rs2=x0 data is treated as normal zero operands; no special case.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined:
//   - MUL* ops bypass CALC; the 33x33 signed product is computed and registered in one step.
//   - done_o at T+1; hold_req_o high only in the start cycle. Divide is unchanged.
//  MULDIV_FAST_MUL_EN undefined: iterative 32-cycle multiply as above. Smaller area, no DSP use.
// TESTING
//  1. MUL 7 x -3 -> done_o at T+33 (T+1 with MULDIV_FAST_MUL_EN), result_o=0xFFFF_FFEB, hold_req_o high T..T+32.
//  2. MULH 0x8000_0000 x 0x8000_0000 -> result_o=0x4000_0000; MULHU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFE.
//  3. DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  4. DIV 5/0 -> 0xFFFF_FFFF at T+1; REM 5/0 -> 5; DIV 0x8000_0000/-1 -> 0x8000_0000, REM -> 0.
//  5. flush_i at T+10 of a DIVU -> IDLE at T+11, no done_o, hold_req_o low; the next op completes normally.
//  6. rst pulse at T+5 of MULHU -> all outputs 0 immediately; start_i+flush_i in the same cycle -> op not accepted.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage; `define MULDIV_FAST_MUL_EN for single-step multiply
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      w_reg_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            hold_req_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      w_reg_addr_o
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc, mc, acc_nx, prod;
  logic [XLEN-1:0]   mp, abs1, abs2, short_res, fast_res, calc_res, quo, rem, rem_diff;
  logic [XLEN:0]     rem_sh;
  logic [2:0]        op;
  logic              neg, neg_r, s1, s2, accept, div0, ovf, fast, last;
  assign accept = state == IDLE && start_i && !flush_i;
  assign s1 = rs1_data_i[XLEN-1] && !(op_i == 3'b011 || (op_i[2] && op_i[0]));
  assign s2 = rs2_data_i[XLEN-1] && (op_i == 3'b000 || op_i == 3'b001 || op_i == 3'b100 || op_i == 3'b110);
  assign abs1 = s1 ? -rs1_data_i : rs1_data_i;
  assign abs2 = s2 ? -rs2_data_i : rs2_data_i;
  assign div0 = op_i[2] && rs2_data_i == '0;
  assign ovf = op_i[2] && !op_i[0] && rs1_data_i == {1'b1, {(XLEN-1){1'b0}}} && rs2_data_i == '1;
  assign short_res = div0 ? (op_i[1] ? rs1_data_i : '1) : (op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast = !op_i[2];
  assign fast_prod = (2*XLEN)'($signed({s1, rs1_data_i})) * (2*XLEN)'($signed({s2, rs2_data_i}));
  assign fast_res = op_i == 3'b000 ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
  assign fast = 1'b0;
  assign fast_res = '0;
`endif
  // one iteration: shift-add for multiply, shift-compare-subtract for divide
  assign last = cnt == CNT_W'(XLEN-1);
  assign rem_sh = acc[2*XLEN-1:XLEN-1];
  assign rem_diff = rem_sh[XLEN-1:0] - mp;
  assign acc_nx = op[2] ? (rem_sh >= {1'b0, mp} ? {rem_diff, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0})
                        : acc + (mp[0] ? mc : '0);
  assign prod = neg ? -acc_nx : acc_nx;
  assign quo = acc_nx[XLEN-1:0];
  assign rem = acc_nx[2*XLEN-1:XLEN];
  assign calc_res = op[2] ? (op[1] ? (neg_r ? -rem : rem) : (neg ? -quo : quo))
                          : (op == 3'b000 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state and status outputs; flush always returns to IDLE
  always_comb begin
    state_nx = state;
    state_nx = flush_i ? IDLE :
               state == IDLE ? (accept ? ((div0 || ovf || fast) ? DONE : CALC) : IDLE) :
               state == CALC ? (last ? DONE : CALC) : IDLE;
    busy_o = state != IDLE;
    done_o = state == DONE;
    hold_req_o = accept || state == CALC;
  end
  // operand capture, iteration datapath and result register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      mc <= '0;
      mp <= '0;
      op <= '0;
      neg <= 1'b0;
      neg_r <= 1'b0;
      result_o <= '0;
      w_reg_addr_o <= '0;
    end else if (accept) begin
      cnt <= '0;
      op <= op_i;
      neg <= s1 ^ s2;
      neg_r <= s1;
      mp <= abs2;
      mc <= {{XLEN{1'b0}}, abs1};
      acc <= op_i[2] ? {{XLEN{1'b0}}, abs1} : '0;
      w_reg_addr_o <= w_reg_addr_i;
      if (div0 || ovf || fast) result_o <= (div0 || ovf) ? short_res : fast_res;
    end else if (state == CALC && !flush_i) begin
      cnt <= cnt + 1'b1;
      acc <= acc_nx;
      mc <= mc << 1;
      mp <= op[2] ? mp : mp >> 1;
      if (last) result_o <= calc_res;
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vectors for ex_muldiv checked against a cycle-level arithmetic model
module tb_ex_muldiv;
`ifdef MULDIV_FAST_MUL_EN
  localparam int LM = 1;
`else
  localparam int LM = 33;
`endif
  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  wa;
  logic        busy_o, hold_req_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  w_reg_addr_o;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        m_pend, m_done, m_busy, m_hold;
  int          m_left;
  logic [31:0] m_res, m_pres;
  logic [4:0]  m_wa;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .rs1_data_i(a), .rs2_data_i(b),
    .w_reg_addr_i(wa), .flush_i(flush), .busy_o(busy_o), .hold_req_o(hold_req_o),
    .done_o(done_o), .result_o(result_o), .w_reg_addr_o(w_reg_addr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, ux, uy, p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      3'd0: p = sx * sy;
      3'd1: begin p = sx * sy; p = p >>> 32; end
      3'd2: begin p = sx * uy; p = p >>> 32; end
      3'd3: begin p = ux * uy; p = p >> 32; end
      3'd4: p = (y == 0) ? -64'sd1 : (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? sx : sx / sy;
      3'd5: p = (y == 0) ? -64'sd1 : ux / uy;
      3'd6: p = (y == 0) ? ux : (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? 64'sd0 : sx % sy;
      default: p = (y == 0) ? ux : ux % uy;
    endcase
    return p[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[2]) return 1;
`endif
    return 33;
  endfunction

  assign m_busy = m_pend || m_done;
  assign m_hold = (!m_busy && start && !flush) || m_pend;

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_pend <= 0; m_done <= 0; m_left <= 0; m_res <= 0; m_pres <= 0; m_wa <= 0;
    end else begin
      m_done <= 0;
      if (flush) m_pend <= 0;
      else if (m_pend) begin
        if (m_left == 0) begin m_pend <= 0; m_done <= 1; m_res <= m_pres; end
        else m_left <= m_left - 1;
      end else if (!m_done && start) begin
        m_wa <= wa;
        if (ref_lat(op, a, b) == 1) begin m_done <= 1; m_res <= ref_res(op, a, b); end
        else begin m_pend <= 1; m_left <= ref_lat(op, a, b) - 2; m_pres <= ref_res(op, a, b); end
      end
    end

  always @(negedge clk) begin
    chk("busy", 32'(busy_o), 32'(m_busy));
    chk("done", 32'(done_o), 32'(m_done));
    chk("hold", 32'(hold_req_o), 32'(m_hold));
    chk("result", result_o, m_res);
    if (m_done) chk("waddr", 32'(w_reg_addr_o), 32'(m_wa));
  end

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] w, input logic [31:0] e, input int l);
    int k;
    op = o; a = x; b = y; wa = w; start = 1;
    @(posedge clk); #1 start = 0;
    k = 1;
    while (k <= 40) begin
      @(negedge clk);
      if (done_o) break;
      @(posedge clk); #1;
      k++;
    end
    chk($sformatf("op%0d_latency", o), 32'(k), 32'(l));
    chk($sformatf("op%0d_result", o), result_o, e);
    if (k <= 40) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1; start = 0; flush = 0; op = 0; a = 0; b = 0; wa = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_result", result_o, 0);
    chk("rst_waddr", 32'(w_reg_addr_o), 0);
    @(posedge clk); #1;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, LM);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, LM);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, LM);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 33);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 33);
    run_op(3'd5, 32'd100, 32'd7, 5'd6, 32'd14, 33);
    run_op(3'd7, 32'd100, 32'd7, 5'd7, 32'd2, 33);
    run_op(3'd4, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1);
    run_op(3'd6, 32'd5, 32'd0, 5'd9, 32'd5, 1);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 1);
    run_op(3'd5, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 1);
    run_op(3'd7, 32'd5, 32'd0, 5'd13, 32'd5, 1);
    run_op(3'd4, 32'd7, 32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD, 33);
    run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd15, 32'd1, 33);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_FFFF, LM);
    run_op(3'd1, 32'hFFFF_FFFD, 32'd7, 5'd17, 32'hFFFF_FFFF, LM);
    run_op(3'd3, 32'h8000_0000, 32'd4, 5'd18, 32'd2, LM);
    run_op(3'd5, 32'hFFFF_FFFF, 32'h10, 5'd19, 32'h0FFF_FFFF, 33);
    run_op(3'd7, 32'hFFFF_FFFF, 32'h10, 5'd20, 32'hF, 33);
    run_op(3'd4, 32'h8000_0000, 32'd2, 5'd21, 32'hC000_0000, 33);
    run_op(3'd6, 32'h8000_0000, 32'd3, 5'd22, 32'hFFFF_FFFE, 33);
    run_op(3'd0, 32'd0, 32'd0, 5'd0, 32'd0, LM);
    run_op(3'd5, 32'd0, 32'd5, 5'd23, 32'd0, 33);
    // flush in the middle of a DIVU
    op = 3'd5; a = 32'd1000; b = 32'd3; wa = 5'd24; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1;
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    chk("flush_busy", 32'(busy_o), 0);
    chk("flush_hold", 32'(hold_req_o), 0);
    chk("flush_done", 32'(done_o), 0);
    chk("flush_result_held", result_o, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    run_op(3'd5, 32'd1000, 32'd3, 5'd25, 32'd333, 33);
    // reset in the middle of a MULHU
    op = 3'd3; a = 32'h1234_5678; b = 32'h9ABC_DEF0; wa = 5'd26; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (4) begin @(posedge clk); #1; end
    #1 rst = 1;
    #1;
    chk("midrst_busy", 32'(busy_o), 0);
    chk("midrst_done", 32'(done_o), 0);
    chk("midrst_hold", 32'(hold_req_o), 0);
    chk("midrst_result", result_o, 0);
    chk("midrst_waddr", 32'(w_reg_addr_o), 0);
    #1 rst = 0;
    @(posedge clk); #1;
    start = 1; flush = 1;
    @(negedge clk);
    chk("startflush_hold", 32'(hold_req_o), 0);
    @(posedge clk); #1 start = 0; flush = 0;
    @(negedge clk);
    chk("startflush_busy", 32'(busy_o), 0);
    repeat (40) @(posedge clk);
    #1;
    run_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd27, 32'h0B00_EA4E, LM);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
